// File: rtl/umi_rr_arbiter.sv
// Round-robin arbiter that funnels N UMI packet sources into one registered
// output stage with valid/ready flow control.
module umi_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] in_packet,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [DW-1:0]   out_packet,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last;
    logic [PW-1:0] win;
    logic          found;
    logic          load;
    int            idx;

    assign load = ~out_valid | out_ready;

    // Search starts just after the most recent grant so every requester
    // gets a turn before anyone is served twice.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (found && load && !rst) begin
            in_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_packet <= '0;
            last       <= PW'(N - 1);
        end else if (load) begin
            if (found) begin
                out_packet <= in_packet[int'(win)*DW +: DW];
                out_valid  <= 1'b1;
                last       <= win;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Bench for umi_rr_arbiter: a round-robin reference model checked every
// cycle, plus directed scenarios with hand-computed grants and packets.
module tb_umi_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] in_packet;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_packet;
    logic            out_valid;
    logic            out_ready;

    int checks;
    int errors;

    umi_rr_arbiter #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_packet  (in_packet),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pointer to the last winner and a one-slot buffer.
    int            m_last;
    logic          m_valid;
    logic [DW-1:0] m_pkt;
    int            m_win;

    function automatic int find_winner(input logic [N-1:0] v, input int from);
        int d;
        d = 1;
        while (d <= N) begin
            if (v[(from + d) % N]) return (from + d) % N;
            d++;
        end
        return -1;
    endfunction

    always_comb m_win = find_winner(in_valid, m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last  <= N - 1;
            m_valid <= 1'b0;
            m_pkt   <= '0;
        end else if (!m_valid || out_ready) begin
            if (m_win >= 0) begin
                m_pkt   <= in_packet[m_win*DW +: DW];
                m_valid <= 1'b1;
                m_last  <= m_win;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle the model is compared with the DUT away from the clock edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        exp_ready = '0;
        if (!rst && (!m_valid || out_ready) && m_win >= 0) exp_ready[m_win] = 1'b1;
        checkOutput("model_in_ready", DW'(in_ready), DW'(exp_ready));
        checkOutput("model_out_valid", DW'(out_valid), DW'(m_valid));
        if (m_valid) checkOutput("model_out_packet", out_packet, m_pkt);
    end

    task automatic applyStimulus(input logic [N-1:0] valid, input logic ready);
        in_valid  = valid;
        out_ready = ready;
    endtask

    task automatic setPacket(input int i, input logic [DW-1:0] val);
        in_packet[i*DW +: DW] = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_packet = '0;
        applyStimulus(4'b1111, 1'b1);
        for (int i = 0; i < N; i++) setPacket(i, DW'(32'hC0 + i));

        // Reset holds everything quiet even with all requesters valid.
        repeat (2) tick();
        @(negedge clk);
        checkOutput("reset_in_ready", DW'(in_ready), '0);
        checkOutput("reset_out_valid", DW'(out_valid), '0);
        checkOutput("reset_out_packet", out_packet, '0);
        tick();
        rst = 1'b0;

        // Full contention straight out of reset.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("contend_grant%0d", i), DW'(in_ready),
                        DW'(4'b0001 << exp_order[i]));
            if (i > 0) checkOutput($sformatf("contend_pkt%0d", i), out_packet,
                                   DW'(32'hC0 + exp_order[i-1]));
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        tick();

        // Single requester 2 streaming back-to-back.
        for (int j = 0; j < 4; j++) begin
            setPacket(2, DW'(32'hA0 + j));
            applyStimulus(4'b0100, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("single_ready%0d", j), DW'(in_ready), DW'(4'b0100));
            if (j > 0) begin
                checkOutput($sformatf("single_pkt%0d", j), out_packet, DW'(32'hA0 + j - 1));
                checkOutput($sformatf("single_valid%0d", j), DW'(out_valid), DW'(1));
            end
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("single_pkt_last", out_packet, DW'(32'hA3));
        tick();

        // Backpressure: 0x55 from requester 1 held while 0 and 3 wait.
        setPacket(1, DW'(32'h55));
        setPacket(3, DW'(32'h33));
        setPacket(0, DW'(32'h10));
        applyStimulus(4'b0010, 1'b1);
        tick();
        applyStimulus(4'b1001, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", DW'(in_ready), '0);
            checkOutput("stall_out_packet", out_packet, DW'(32'h55));
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_grant3", DW'(in_ready), DW'(4'b1000));
        tick();

        // Pointer wrap: last is 3, so 0 beats 3.
        setPacket(3, DW'(32'h34));
        applyStimulus(4'b1001, 1'b1);
        @(negedge clk);
        checkOutput("wrap_first0", DW'(in_ready), DW'(4'b0001));
        tick();
        applyStimulus(4'b1000, 1'b1);
        @(negedge clk);
        checkOutput("wrap_then3", DW'(in_ready), DW'(4'b1000));
        tick();

        // Drain and load in the same edge.
        setPacket(0, DW'(32'h11));
        applyStimulus(4'b0001, 1'b1);
        tick();
        setPacket(0, DW'(32'h22));
        @(negedge clk);
        checkOutput("dl_old_pkt", out_packet, DW'(32'h11));
        checkOutput("dl_ready", DW'(in_ready), DW'(4'b0001));
        tick();
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("dl_new_pkt", out_packet, DW'(32'h22));
        checkOutput("dl_valid", DW'(out_valid), DW'(1));

        // Asynchronous reset in the middle of a stall.
        setPacket(0, DW'(32'hB0));
        setPacket(1, DW'(32'hB1));
        setPacket(2, DW'(32'hB2));
        applyStimulus(4'b0111, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", DW'(out_valid), '0);
        checkOutput("arst_out_packet", out_packet, '0);
        checkOutput("arst_in_ready", DW'(in_ready), '0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_grant0", DW'(in_ready), DW'(4'b0001));
        tick();
        applyStimulus(4'b0110, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_grant1", DW'(in_ready), DW'(4'b0010));
        checkOutput("post_rst_pkt0", out_packet, DW'(32'hB0));
        tick();
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_grant2", DW'(in_ready), DW'(4'b0100));
        tick();
        applyStimulus(4'b0000, 1'b1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
